// File: rtl/hwpe_stream_tcdm_load_buffer.sv
// -----------------------------------------------------------------------------
// hwpe_stream_tcdm_load_buffer
//
// Purpose:
//   Credit-based load buffer between a source address generator and a TCDM
//   port. A request is forwarded to TCDM only while the response FIFO has
//   room for it, counting both buffered words and the single in-flight
//   request. This guarantees that every TCDM response can be stored.
//   Responses leave as a valid/ready stream in first-in first-out order.
//   clear_i flushes the buffer. A response to a request that was in flight
//   at flush time is discarded when it arrives in the cycle after the flush.
//
// Configuration macro:
//   HWPE_STREAM_LOAD_BUFFER_FALLTHROUGH_EN
//     Undefined (default): every response is written to the FIFO and is
//       visible on the output stream at the earliest one cycle later.
//     Defined: a response that arrives while the FIFO is empty is shown
//       combinationally on the output in the same cycle. It is stored only
//       if the consumer does not take it in that cycle.
//
// Parameters:
//   DEPTH        response FIFO entries (power of two, >= 2)
//   ADDR_WIDTH   TCDM address width
//   DATA_WIDTH   TCDM word width
//
// Ports:
//   clk_i           clock
//   rst_i           synchronous active-high reset
//   clear_i         synchronous soft flush
//   in_req_i/in_add_i/in_gnt_o            upstream load request, address, grant
//   tcdm_req_o/tcdm_add_o                 TCDM request and address
//   tcdm_wen_o/tcdm_be_o/tcdm_data_o      TCDM write controls (tied to load-only)
//   tcdm_gnt_i/tcdm_r_valid_i/tcdm_r_data_i  TCDM grant and response
//   out_valid_o/out_data_o/out_ready_i    response stream
//   occupancy_o     buffered words plus the in-flight request
// -----------------------------------------------------------------------------
module hwpe_stream_tcdm_load_buffer #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clear_i,
    input  logic                           in_req_i,
    input  logic [ADDR_WIDTH-1:0]          in_add_i,
    output logic                           in_gnt_o,
    output logic                           tcdm_req_o,
    output logic [ADDR_WIDTH-1:0]          tcdm_add_o,
    output logic                           tcdm_wen_o,
    output logic [DATA_WIDTH/8-1:0]        tcdm_be_o,
    output logic [DATA_WIDTH-1:0]          tcdm_data_o,
    input  logic                           tcdm_gnt_i,
    input  logic                           tcdm_r_valid_i,
    input  logic [DATA_WIDTH-1:0]          tcdm_r_data_i,
    output logic                           out_valid_o,
    output logic [DATA_WIDTH-1:0]          out_data_o,
    input  logic                           out_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH+1);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]      count_q, count_d;
    logic                  infl_q, infl_d;
    logic                  drop_q, drop_d;

    logic                  fifo_empty;
    logic [OCC_W-1:0]      occupancy;
    logic                  credit_ok;
    logic                  accept;
    logic                  bypass;
    logic                  push;
    logic                  pop;

    // Load-only port: write controls are constant.
    assign tcdm_wen_o  = 1'b1;
    assign tcdm_be_o   = '0;
    assign tcdm_data_o = '0;

    assign fifo_empty  = (count_q == '0);
    assign occupancy   = count_q + OCC_W'(infl_q);
    assign occupancy_o = occupancy;

    // Credit is computed from registered state only, so a pop frees a slot
    // one cycle later. It is also withheld during reset so that no grant
    // is issued while reset is held.
    assign credit_ok  = (occupancy < DEPTH_OCC) && !clear_i && !rst_i;
    assign tcdm_req_o = in_req_i & credit_ok;
    assign tcdm_add_o = in_add_i;
    assign in_gnt_o   = tcdm_gnt_i & tcdm_req_o;

    // A response is genuine only in the cycle after a grant. Responses that
    // belong to a flushed request (drop_q) or that arrive with nothing
    // outstanding are ignored.
    assign accept = tcdm_r_valid_i & infl_q & ~drop_q & ~clear_i;

`ifdef HWPE_STREAM_LOAD_BUFFER_FALLTHROUGH_EN
    assign bypass      = fifo_empty & accept;
    assign out_valid_o = ~fifo_empty | bypass;
    assign out_data_o  = fifo_empty ? tcdm_r_data_i : mem_q[rd_ptr_q];
`else
    assign bypass      = 1'b0;
    assign out_valid_o = ~fifo_empty;
    assign out_data_o  = mem_q[rd_ptr_q];
`endif

    assign pop  = out_valid_o & out_ready_i & ~fifo_empty;
    assign push = accept & ~(bypass & out_ready_i);

    always_comb begin
        // NOTE: every _d signal gets its hold value before any branch, so no path leaves it unassigned and no latch is inferred.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        infl_d   = infl_q;
        drop_d   = 1'b0;

        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            infl_d   = 1'b0;
            drop_d   = infl_q;
        end else begin
            infl_d = in_gnt_o;
            // Power-of-two depth: pointers wrap by natural overflow.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop) begin
                count_d = count_q + OCC_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - OCC_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            infl_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            infl_q   <= infl_d;
            drop_q   <= drop_d;
        end
    end

    // NOTE: storage has no reset; an entry is only read after it has been written, and out_data_o is don't-care while out_valid_o is low.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tcdm_r_data_i;
        end
    end

endmodule
